// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch: display state encoding,
// BCD digit limits and elaboration-time helpers.
package stopwatch_bcd_counter_pkg;

  typedef enum logic {
    LIVE = 1'b0,
    LAP  = 1'b1
  } state_t;

  localparam logic [3:0] BCD_NINE     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Binary 0..99 to two packed BCD digits {tens, ones}.
  function automatic logic [7:0] to_bcd8(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

  // Next value of one BCD digit; shared by the digit counters and the
  // display path so both always agree on the count of the coming edge.
  function automatic logic [3:0] digit_next(input logic [3:0] q,
                                            input logic       inc,
                                            input logic [3:0] limit,
                                            input logic       load_zero);
    if (load_zero)  return 4'd0;
    if (!inc)       return q;
    if (q == limit) return 4'd0;
    return q + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch count; rolls over at LIMIT and offers a
// combinational carry so digits chain into a ripple enable.
module bcd_digit_cnt
  import stopwatch_bcd_counter_pkg::*;
#(
  parameter logic [3:0] LIMIT = BCD_NINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       load_zero,
  output logic [3:0] q,
  output logic       carry
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // digit samples its neighbours' pre-edge values at the same clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= 4'd0;
    else if (clr) q <= 4'd0;
    else          q <= digit_next(q, inc, LIMIT, load_zero);
  end

  assign carry = inc & (q == LIMIT);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD stopwatch fed by the gated 1 Hz tick; drives the 4-digit display
// bus with lap freeze, synchronous clear and a one-cycle wrap pulse.
module stopwatch_bcd_counter
  import stopwatch_bcd_counter_pkg::*;
#(
  parameter int MAX_MINUTES = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       lap_active,
  output logic       wrap
);

  localparam logic [7:0] MAX_MIN_BCD = to_bcd8(MAX_MINUTES);

  logic       tick_d;
  logic       step;
  state_t     state;

  logic [3:0] q_so, q_st, q_mo, q_mt;
  logic       c_so, c_st, c_mo, c_mt;
  logic       min_at_max;
  logic       wrap_hit;
  logic       disp_load;
  logic [3:0] n_so, n_st, n_mo, n_mt;

  assign step = tick & ~tick_d;

  assign min_at_max = ({q_mt, q_mo} == MAX_MIN_BCD);
  // The min_tens carry is the natural 99:59 rollover, i.e. the wrap point
  // when MAX_MINUTES is 99; for smaller limits it can never fire.
  assign wrap_hit = (c_st & min_at_max) | c_mt;

  bcd_digit_cnt #(.LIMIT(BCD_NINE)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(step), .load_zero(wrap_hit),
    .q(q_so), .carry(c_so)
  );

  bcd_digit_cnt #(.LIMIT(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_so), .load_zero(wrap_hit),
    .q(q_st), .carry(c_st)
  );

  bcd_digit_cnt #(.LIMIT(BCD_NINE)) u_min_ones (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_st), .load_zero(wrap_hit),
    .q(q_mo), .carry(c_mo)
  );

  bcd_digit_cnt #(.LIMIT(BCD_NINE)) u_min_tens (
    .clk(clk), .rst(rst), .clr(clear), .inc(c_mo), .load_zero(wrap_hit),
    .q(q_mt), .carry(c_mt)
  );

  assign n_so = digit_next(q_so, step, BCD_NINE,     wrap_hit);
  assign n_st = digit_next(q_st, c_so, SEC_TENS_MAX, wrap_hit);
  assign n_mo = digit_next(q_mo, c_st, BCD_NINE,     wrap_hit);
  assign n_mt = digit_next(q_mt, c_mo, BCD_NINE,     wrap_hit);

  // Display follows the count in LIVE unless entering LAP, and reloads on the
  // edge that leaves LAP.
  assign disp_load = (state == LIVE) ^ lap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_d   <= 1'b0;
      state    <= LIVE;
      wrap     <= 1'b0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else begin
      tick_d <= tick;
      if (clear) begin
        state    <= LIVE;
        wrap     <= 1'b0;
        sec_ones <= 4'd0;
        sec_tens <= 4'd0;
        min_ones <= 4'd0;
        min_tens <= 4'd0;
      end else begin
        wrap <= wrap_hit;
        if (lap) state <= (state == LIVE) ? LAP : LIVE;
        if (disp_load) begin
          sec_ones <= n_so;
          sec_tens <= n_st;
          min_ones <= n_mo;
          min_tens <= n_mt;
        end
      end
    end
  end

  assign lap_active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: a cycle-level seconds model
// pushes expected display/flags into a scoreboard checked after each edge.
module tb_stopwatch_bcd_counter;

  localparam int MAX_MIN = 59;
  localparam int MAX_CNT = MAX_MIN * 60 + 59;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       lap_active, wrap;

  stopwatch_bcd_counter #(.MAX_MINUTES(MAX_MIN)) dut (
    .clk(clk), .rst(rst), .tick(tick), .clear(clear), .lap(lap),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .lap_active(lap_active), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic        lap_active;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state, kept in plain seconds.
  int m_count, m_disp;
  bit m_tick_d, m_lap, m_wrap;

  wire [15:0] disp = {min_tens, min_ones, sec_tens, sec_ones};

  function automatic logic [15:0] to_disp(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_disp   = 0;
    m_tick_d = 1'b0;
    m_lap    = 1'b0;
    m_wrap   = 1'b0;
  endtask

  // One clock: drive inputs, predict, then compare just after the edge.
  task automatic cycle(input bit t, input bit c, input bit l);
    bit   st;
    int   ncount;
    exp_t e;
    tick  = t;
    clear = c;
    lap   = l;
    st       = t & ~m_tick_d;
    m_tick_d = t;
    if (c) begin
      m_count = 0;
      m_disp  = 0;
      m_lap   = 1'b0;
      m_wrap  = 1'b0;
    end else begin
      m_wrap = st && (m_count == MAX_CNT);
      ncount = st ? ((m_count == MAX_CNT) ? 0 : m_count + 1) : m_count;
      if (!m_lap) begin
        if (l) m_lap = 1'b1;
        else   m_disp = ncount;
      end else if (l) begin
        m_lap  = 1'b0;
        m_disp = ncount;
      end
      m_count = ncount;
    end
    sb.push_back('{disp: to_disp(m_disp), lap_active: m_lap, wrap: m_wrap});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("cyc_disp", 32'(disp), 32'(e.disp));
    check("cyc_lap_active", 32'(lap_active), 32'(e.lap_active));
    check("cyc_wrap", 32'(wrap), 32'(e.wrap));
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_disp", 32'(disp), 32'h0);
    check("reset_lap_active", 32'(lap_active), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    rst = 1'b1;

    // Ten single-cycle ticks.
    tick_n(10);
    check("ten_ticks", 32'(disp), 32'h0010);

    // A level held for 50 cycles counts once.
    repeat (50) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("held_tick", 32'(disp), 32'h0011);

    // Lap freeze while the count keeps running.
    cycle(1'b0, 1'b1, 1'b0);
    tick_n(5);
    cycle(1'b0, 1'b0, 1'b1);
    check("lap_frozen", 32'(disp), 32'h0005);
    check("lap_active_on", 32'(lap_active), 32'h1);
    tick_n(7);
    check("lap_still_frozen", 32'(disp), 32'h0005);
    cycle(1'b0, 1'b0, 1'b1);
    check("lap_release", 32'(disp), 32'h0012);
    check("lap_active_off", 32'(lap_active), 32'h0);

    // Step and lap in the same cycle, both directions.
    cycle(1'b1, 1'b0, 1'b1);
    check("step_lap_enter", 32'(disp), 32'h0012);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check("step_lap_leave", 32'(disp), 32'h0014);

    // Clear wins over a tick in the same cycle.
    cycle(1'b0, 1'b1, 1'b0);
    tick_n(30);
    check("at_0030", 32'(disp), 32'h0030);
    cycle(1'b1, 1'b1, 1'b0);
    check("clear_with_tick", 32'(disp), 32'h0000);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("after_clear_tick", 32'(disp), 32'h0001);

    // Rollover 59:59 -> 00:00 with a one-cycle wrap.
    cycle(1'b0, 1'b1, 1'b0);
    tick_n(MAX_CNT);
    check("preload_max", 32'(disp), 32'h5959);
    cycle(1'b1, 1'b0, 1'b0);
    check("wrap_disp", 32'(disp), 32'h0000);
    check("wrap_pulse", 32'(wrap), 32'h1);
    cycle(1'b0, 1'b0, 1'b0);
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // Wrap still pulses in LAP while the display stays frozen.
    tick_n(MAX_CNT);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    check("lap_wrap_pulse", 32'(wrap), 32'h1);
    check("lap_wrap_frozen", 32'(disp), 32'h5959);
    cycle(1'b0, 1'b0, 1'b1);
    check("lap_wrap_release", 32'(disp), 32'h0000);

    // Asynchronous reset between edges, taken from LAP at 03:17.
    cycle(1'b0, 1'b1, 1'b0);
    tick_n(197);
    check("at_0317", 32'(disp), 32'h0317);
    cycle(1'b0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_disp", 32'(disp), 32'h0);
    check("async_rst_lap_active", 32'(lap_active), 32'h0);
    check("async_rst_wrap", 32'(wrap), 32'h0);
    model_reset();
    #2 rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("post_rst_live_tick", 32'(disp), 32'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
